pipelined_ctrl_decoder: RTL and testbench

Registered, handshaked successor to the combinational control sub-decoder. It takes a raw 32-bit RV32I instruction plus its PC, and classifies the opcode itself (no external type one-hots). It produces the full datapath control bundle one cycle later through a pipeline register backed by a one-entry skid buffer. Branch resolution moves downstream: it emits a branch mode code instead of a PC select, and it adds illegal-instruction detection, flush, and a saturating decode counter.

---
 rtl/pipelined_ctrl_decoder.sv | 165 ++++++++++++++++
 tb/tb_pipelined_ctrl_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipelined_ctrl_decoder.sv
// pipelined_ctrl_decoder: registered RV32I control decoder with skid buffer, flush and saturating decode counter
module pipelined_ctrl_decoder #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16,
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic             reg_wen,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       data_wsel,
  output logic             mem_rw,
  output logic [2:0]       data_rsel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       br_mode,
  output logic             br_unsigned,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            reg_wen;
    logic            asel;
    logic            bsel;
    logic [1:0]      data_wsel;
    logic            mem_rw;
    logic [2:0]      data_rsel;
    logic [1:0]      wb_sel;
    logic [2:0]      br_mode;
    logic            br_unsigned;
    logic            illegal;
  } bundle_t;
  bundle_t dec, out_d, out_q, skid_d, skid_q;
  logic out_valid_d, out_valid_q, skid_full_d, skid_full_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [6:0] op;
  logic [2:0] f3;
  logic ill, in_xfer, out_xfer;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign in_ready = ~rst & ~skid_full_q;
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;
  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (op)
      7'b0110011: begin
        dec.reg_wen = 1'b1;
        dec.wb_sel = 2'b01;
      end
      7'b0010011, 7'b0110111: begin
        dec.bsel = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel = 2'b01;
      end
      7'b0000011: begin
        dec.bsel = 1'b1;
        dec.reg_wen = 1'b1;
        dec.data_rsel = f3 == 3'b000 ? 3'b001 : f3 == 3'b001 ? 3'b010 : f3 == 3'b010 ? 3'b000 : f3 == 3'b100 ? 3'b011 : 3'b100;
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      7'b0100011: begin
        dec.bsel = 1'b1;
        dec.mem_rw = 1'b1;
        dec.data_wsel = f3 == 3'b000 ? 2'b01 : f3 == 3'b001 ? 2'b11 : 2'b00;
        ill = f3 >= 3'b011;
      end
      7'b1100011: begin
        dec.asel = 1'b1;
        dec.bsel = 1'b1;
        dec.br_mode = f3[2] ? {2'b10, f3[0]} : {2'b01, f3[0]};
        dec.br_unsigned = f3[1];
        ill = f3[2:1] == 2'b01;
      end
      7'b1101111: begin
        dec.asel = 1'b1;
        dec.bsel = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel = 2'b10;
        dec.br_mode = 3'b001;
      end
      7'b1100111: begin
        dec.bsel = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel = 2'b10;
        dec.br_mode = 3'b001;
        ill = f3 != 3'b000;
      end
      7'b0010111: begin
        dec.asel = 1'b1;
        dec.bsel = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel = 2'b01;
      end
      7'b0001111, 7'b1110011: dec.wb_sel = 2'b01;
      default: ill = 1'b1;
    endcase
    if (ill) dec = '0;
    dec.illegal = ill;
    if (RD0_SUPPRESS && in_instr[11:7] == 5'd0) dec.reg_wen = 1'b0;
    dec.instr = in_instr;
    dec.pc = in_pc;
  end
  always_comb begin
    out_d = out_q;
    skid_d = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    cnt_d = (out_xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (flush) begin
      out_d = '0;
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
      cnt_d = cnt_q;
    end else if (!out_valid_q || out_xfer) begin
      out_valid_d = skid_full_q | in_xfer;
      skid_full_d = 1'b0;
      out_d = skid_full_q ? skid_q : in_xfer ? dec : out_q;
    end else if (in_xfer) begin
      skid_d = dec;
      skid_full_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_instr = out_q.instr;
  assign out_pc = out_q.pc;
  assign reg_wen = out_q.reg_wen;
  assign asel = out_q.asel;
  assign bsel = out_q.bsel;
  assign data_wsel = out_q.data_wsel;
  assign mem_rw = out_q.mem_rw;
  assign data_rsel = out_q.data_rsel;
  assign wb_sel = out_q.wb_sel;
  assign br_mode = out_q.br_mode;
  assign br_unsigned = out_q.br_unsigned;
  assign illegal = out_q.illegal;
  assign dec_cnt = cnt_q;
endmodule

// File: tb/tb_pipelined_ctrl_decoder.sv
// tb_pipelined_ctrl_decoder: directed self-checking bench for pipelined_ctrl_decoder
module tb_pipelined_ctrl_decoder;
  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic in_ready, out_valid, reg_wen, asel, bsel, mem_rw, br_unsigned, illegal;
  logic [31:0] out_instr, out_pc;
  logic [1:0] data_wsel, wb_sel;
  logic [2:0] data_rsel, br_mode;
  logic [15:0] dec_cnt;
  logic s_in_ready, s_out_valid, s_reg_wen, s_asel, s_bsel, s_mem_rw, s_br_unsigned, s_illegal;
  logic [31:0] s_out_instr, s_out_pc;
  logic [1:0] s_data_wsel, s_wb_sel;
  logic [2:0] s_data_rsel, s_br_mode;
  logic [1:0] s_cnt;
  int tests = 0;
  int fails = 0;
  localparam logic [31:0] ADD = 32'h003100B3, LW = 32'h0080A283, SB = 32'h00208223;
  localparam logic [31:0] BNE = 32'h00209463, JAL = 32'h008000EF, ADDI0 = 32'h00000013;
  localparam logic [31:0] LBU = 32'h0000C283, BAD = 32'hFFFFFFFF, LDF3 = 32'h0000B003;
  always #5 clk = ~clk;
  pipelined_ctrl_decoder #(.XLEN(32), .CNT_W(16), .RD0_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .reg_wen(reg_wen), .asel(asel), .bsel(bsel),
    .data_wsel(data_wsel), .mem_rw(mem_rw), .data_rsel(data_rsel), .wb_sel(wb_sel),
    .br_mode(br_mode), .br_unsigned(br_unsigned), .illegal(illegal), .dec_cnt(dec_cnt)
  );
  pipelined_ctrl_decoder #(.XLEN(32), .CNT_W(2), .RD0_SUPPRESS(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc), .reg_wen(s_reg_wen), .asel(s_asel), .bsel(s_bsel),
    .data_wsel(s_data_wsel), .mem_rw(s_mem_rw), .data_rsel(s_data_rsel), .wb_sel(s_wb_sel),
    .br_mode(s_br_mode), .br_unsigned(s_br_unsigned), .illegal(s_illegal), .dec_cnt(s_cnt)
  );
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    in_valid = v;
    in_instr = i;
    in_pc = p;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    tests++; if (dec_cnt !== 16'd0) begin fails++; $display("FAIL reset_dec_cnt got %0d want 0", dec_cnt); end
    tests++; if (out_instr !== 32'h0 || reg_wen !== 1'b0 || illegal !== 1'b0) begin fails++; $display("FAIL reset_bundle got instr %h wen %0b ill %0b want 0", out_instr, reg_wen, illegal); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
  endtask
  task automatic test_add;
    out_ready = 1'b1;
    drive(1'b1, ADD, 32'h100);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got %0b want 1", out_valid); end
    tests++; if ({reg_wen, bsel, wb_sel, br_mode, illegal} !== {1'b1, 1'b0, 2'b01, 3'b000, 1'b0}) begin fails++; $display("FAIL add_ctrl got wen %0b bsel %0b wb %b br %b ill %0b", reg_wen, bsel, wb_sel, br_mode, illegal); end
    tests++; if (out_instr !== ADD || out_pc !== 32'h100) begin fails++; $display("FAIL add_pass got %h/%h want %h/100", out_instr, out_pc, ADD); end
    @(posedge clk);
    #1;
    tests++; if (dec_cnt !== 16'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL add_cnt got cnt %0d valid %0b want 1/0", dec_cnt, out_valid); end
  endtask
  task automatic test_back_to_back;
    drive(1'b1, LW, 32'h104);
    tests++; if ({data_rsel, wb_sel, reg_wen, bsel, mem_rw} !== {3'b000, 2'b00, 1'b1, 1'b1, 1'b0}) begin fails++; $display("FAIL lw_ctrl got rsel %b wb %b wen %0b bsel %0b rw %0b", data_rsel, wb_sel, reg_wen, bsel, mem_rw); end
    drive(1'b1, SB, 32'h108);
    in_valid = 1'b0;
    tests++; if ({mem_rw, data_wsel, reg_wen, data_rsel} !== {1'b1, 2'b01, 1'b0, 3'b000}) begin fails++; $display("FAIL sb_ctrl got rw %0b wsel %b wen %0b rsel %b", mem_rw, data_wsel, reg_wen, data_rsel); end
    tests++; if (out_instr !== SB || out_valid !== 1'b1) begin fails++; $display("FAIL sb_pass got %h valid %0b want %h", out_instr, out_valid, SB); end
    @(posedge clk);
    #1;
    tests++; if (dec_cnt !== 16'd3) begin fails++; $display("FAIL b2b_cnt got %0d want 3", dec_cnt); end
  endtask
  task automatic test_branch_jump;
    drive(1'b1, BNE, 32'h10C);
    tests++; if ({br_mode, asel, bsel, reg_wen, br_unsigned, illegal} !== {3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin fails++; $display("FAIL bne_ctrl got br %b asel %0b bsel %0b wen %0b uns %0b ill %0b", br_mode, asel, bsel, reg_wen, br_unsigned, illegal); end
    drive(1'b1, JAL, 32'h110);
    in_valid = 1'b0;
    tests++; if ({br_mode, wb_sel, reg_wen, asel} !== {3'b001, 2'b10, 1'b1, 1'b1}) begin fails++; $display("FAIL jal_ctrl got br %b wb %b wen %0b asel %0b", br_mode, wb_sel, reg_wen, asel); end
    @(posedge clk);
    #1;
    tests++; if (dec_cnt !== 16'd5) begin fails++; $display("FAIL bj_cnt got %0d want 5", dec_cnt); end
    tests++; if (s_cnt !== 2'd3) begin fails++; $display("FAIL sat_cnt_5 got %0d want 3", s_cnt); end
  endtask
  task automatic test_rd0_lbu;
    drive(1'b1, ADDI0, 32'h114);
    tests++; if ({reg_wen, bsel, wb_sel, illegal} !== {1'b0, 1'b1, 2'b01, 1'b0}) begin fails++; $display("FAIL rd0_ctrl got wen %0b bsel %0b wb %b ill %0b", reg_wen, bsel, wb_sel, illegal); end
    drive(1'b1, LBU, 32'h118);
    in_valid = 1'b0;
    tests++; if ({data_rsel, reg_wen, wb_sel} !== {3'b011, 1'b1, 2'b00}) begin fails++; $display("FAIL lbu_ctrl got rsel %b wen %0b wb %b", data_rsel, reg_wen, wb_sel); end
    @(posedge clk);
    #1;
    tests++; if (dec_cnt !== 16'd7) begin fails++; $display("FAIL rd0_cnt got %0d want 7", dec_cnt); end
  endtask
  task automatic test_back_pressure;
    out_ready = 1'b0;
    drive(1'b1, ADD, 32'h200);
    tests++; if (in_ready !== 1'b1 || out_instr !== ADD) begin fails++; $display("FAIL bp_first got rdy %0b instr %h want 1/%h", in_ready, out_instr, ADD); end
    drive(1'b1, LW, 32'h204);
    tests++; if (in_ready !== 1'b0 || out_instr !== ADD) begin fails++; $display("FAIL bp_second got rdy %0b instr %h want 0/%h", in_ready, out_instr, ADD); end
    drive(1'b1, SB, 32'h208);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== ADD || out_pc !== 32'h200 || dec_cnt !== 16'd7) begin fails++; $display("FAIL bp_hold got rdy %0b vld %0b instr %h pc %h cnt %0d", in_ready, out_valid, out_instr, out_pc, dec_cnt); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (out_instr !== LW || out_pc !== 32'h204 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_drain1 got %h pc %h rdy %0b want %h", out_instr, out_pc, in_ready, LW); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++; if (out_instr !== SB || out_valid !== 1'b1) begin fails++; $display("FAIL bp_drain2 got %h vld %0b want %h", out_instr, out_valid, SB); end
    @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0 || dec_cnt !== 16'd10) begin fails++; $display("FAIL bp_end got vld %0b cnt %0d want 0/10", out_valid, dec_cnt); end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, ADD, 32'h300);
    drive(1'b1, LW, 32'h304);
    flush = 1'b1;
    drive(1'b1, SB, 32'h308);
    flush = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_state got vld %0b rdy %0b want 0/1", out_valid, in_ready); end
    tests++; if (reg_wen !== 1'b0 || wb_sel !== 2'b00 || dec_cnt !== 16'd10) begin fails++; $display("FAIL flush_ctrl got wen %0b wb %b cnt %0d want 0/00/10", reg_wen, wb_sel, dec_cnt); end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0 || dec_cnt !== 16'd10) begin fails++; $display("FAIL flush_after got vld %0b cnt %0d want 0/10", out_valid, dec_cnt); end
  endtask
  task automatic test_illegal;
    out_ready = 1'b1;
    drive(1'b1, BAD, 32'h400);
    tests++; if ({illegal, reg_wen, mem_rw, br_mode, wb_sel, bsel} !== {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0}) begin fails++; $display("FAIL ill_ones got ill %0b wen %0b rw %0b br %b wb %b bsel %0b", illegal, reg_wen, mem_rw, br_mode, wb_sel, bsel); end
    tests++; if (out_instr !== BAD || out_pc !== 32'h400) begin fails++; $display("FAIL ill_pass got %h/%h want %h/400", out_instr, out_pc, BAD); end
    drive(1'b1, LDF3, 32'h404);
    in_valid = 1'b0;
    tests++; if ({illegal, reg_wen, mem_rw, data_rsel} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin fails++; $display("FAIL ill_ld got ill %0b wen %0b rw %0b rsel %b", illegal, reg_wen, mem_rw, data_rsel); end
    @(posedge clk);
    #1;
    tests++; if (dec_cnt !== 16'd12 || s_cnt !== 2'd3) begin fails++; $display("FAIL ill_cnt got %0d sat %0d want 12/3", dec_cnt, s_cnt); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch_jump();
    test_rd0_lbu();
    test_back_pressure();
    test_flush();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
